// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result accumulator and its neighbours:
// default widths and the state encoding of the dot-product controller.
package mac_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_SUM_W = DEF_IN_W + 1 + DEF_LEN_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/mac_dot_accum.sv
// Accumulates a fixed number of upstream MAC results ({cout, out} terms) into a
// dot-product sum and hands it downstream with a valid/ready handshake.
module mac_dot_accum
    import mac_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int SUM_W = IN_W + 1 + LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  mac_out,
    input  logic             mac_cout,
    output logic [SUM_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             busy,
    output logic [LEN_W:0]   term_cnt
);

    logic [1:0]       state;
    logic [SUM_W-1:0] acc;
    logic [LEN_W:0]   target;
    logic [LEN_W:0]   cnt;
    logic [LEN_W:0]   cnt_next;
    logic [SUM_W-1:0] term;

    assign term     = SUM_W'({mac_cout, mac_out});
    assign cnt_next = cnt + (LEN_W + 1)'(1);

    // NOTE: all state below is assigned with <= so every register samples the
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            target    <= '0;
            cnt       <= '0;
            sum_valid <= 1'b0;
        end else if (abort) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            sum_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // len == 0 encodes the full 2**LEN_W terms via the extra MSB
                        target <= {(len == '0), len};
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc <= acc + term;
                        cnt <= cnt_next;
                        if (cnt_next == target) begin
                            state     <= ST_DONE;
                            sum_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (sum_ready) begin
                        state     <= ST_IDLE;
                        sum_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sum      = acc;
    assign term_cnt = cnt;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_mac_dot_accum.sv
// Directed bench for mac_dot_accum: expected sums go into a scoreboard queue,
// and a monitor pops and compares them on each completed output handshake.
module tb_mac_dot_accum;
    import mac_pkg::*;

    localparam int IN_W  = DEF_IN_W;
    localparam int LEN_W = DEF_LEN_W;
    localparam int SUM_W = DEF_SUM_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             in_valid;
    logic [IN_W-1:0]  mac_out;
    logic             mac_cout;
    logic [SUM_W-1:0] sum;
    logic             sum_valid;
    logic             sum_ready;
    logic             busy;
    logic [LEN_W:0]   term_cnt;

    int tests  = 0;
    int failed = 0;
    logic [SUM_W-1:0] exp_q[$];

    mac_dot_accum #(.IN_W(IN_W), .LEN_W(LEN_W), .SUM_W(SUM_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .in_valid  (in_valid),
        .mac_out   (mac_out),
        .mac_cout  (mac_cout),
        .sum       (sum),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .busy      (busy),
        .term_cnt  (term_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_op(input logic [LEN_W-1:0] n);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
    endtask

    task automatic send_term(input logic [IN_W:0] v);
        in_valid = 1'b1;
        mac_cout = v[IN_W];
        mac_out  = v[IN_W-1:0];
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: checks hold stability while stalled, pops on each handshake
    logic             held = 1'b0;
    logic [SUM_W-1:0] held_sum;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && sum_valid) begin
                if (held) check("sum_stable", 32'(sum), 32'(held_sum));
                else begin
                    held     = 1'b1;
                    held_sum = sum;
                end
                if (sum_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) check("unexpected_sum", 32'(sum), 32'hFFFF_FFFF);
                    else check("sum", 32'(sum), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [IN_W:0] terms5 [5] = '{17'd150, 17'd500, 17'd1500, 17'd20000, 17'd65025};

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
        in_valid = 1'b0; mac_out = '0; mac_cout = 1'b0; sum_ready = 1'b1;
        idle_cycles(2);
        check("rst_sum", 32'(sum), 0);
        check("rst_sum_valid", 32'(sum_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_term_cnt", 32'(term_cnt), 0);
        rst = 1'b0;
        step();

        // Five products back-to-back, minimum latency
        exp_q.push_back(SUM_W'(87175));
        begin_op(4'd5);
        check("t1_busy", 32'(busy), 1);
        check("t1_cnt0", 32'(term_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("t1_valid_early", 32'(sum_valid), 0);
            send_term(terms5[i]);
        end
        check("t1_valid", 32'(sum_valid), 1);
        check("t1_cnt", 32'(term_cnt), 5);
        step();
        check("t1_idle", 32'(busy), 0);

        // len=0 means sixteen terms; maximum accumulator value
        exp_q.push_back(SUM_W'(21'h1FFFF0));
        begin_op(4'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t2_valid_early", 32'(sum_valid), 0);
            send_term(17'h1FFFF);
        end
        check("t2_valid", 32'(sum_valid), 1);
        check("t2_cnt", 32'(term_cnt), 16);
        step();

        // Gaps between terms add nothing
        exp_q.push_back(SUM_W'(60));
        begin_op(4'd3);
        send_term(17'd10);
        idle_cycles(2);
        check("t3_cnt_gap", 32'(term_cnt), 1);
        send_term(17'd20);
        idle_cycles(2);
        check("t3_cnt_gap2", 32'(term_cnt), 2);
        check("t3_valid_gap", 32'(sum_valid), 0);
        send_term(17'd30);
        check("t3_valid", 32'(sum_valid), 1);
        step();

        // Stall in DONE, then a start during the handshake cycle
        sum_ready = 1'b0;
        exp_q.push_back(SUM_W'(300));
        begin_op(4'd2);
        send_term(17'd100);
        send_term(17'd200);
        for (int i = 0; i < 4; i++) begin
            check("t4_hold_valid", 32'(sum_valid), 1);
            check("t4_hold_busy", 32'(busy), 1);
            step();
        end
        sum_ready = 1'b1;
        start     = 1'b1;
        len       = 4'd1;
        step();
        start = 1'b0;
        check("t4_after_valid", 32'(sum_valid), 0);
        check("t4_after_busy", 32'(busy), 0);
        step();
        check("t4_start_ignored", 32'(busy), 0);

        // Abort beats in_valid; a fresh operation follows
        begin_op(4'd4);
        send_term(17'd1000);
        send_term(17'd2000);
        abort    = 1'b1;
        in_valid = 1'b1;
        mac_out  = 16'd5;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t5_abort_busy", 32'(busy), 0);
        check("t5_abort_valid", 32'(sum_valid), 0);
        check("t5_abort_cnt", 32'(term_cnt), 0);
        exp_q.push_back(SUM_W'(7));
        begin_op(4'd1);
        send_term(17'd7);
        check("t5_valid", 32'(sum_valid), 1);
        step();

        // Reset mid-operation overrides everything; IDLE ignores terms
        begin_op(4'd3);
        send_term(17'd40);
        send_term(17'd50);
        rst      = 1'b1;
        in_valid = 1'b1;
        abort    = 1'b1;
        step();
        rst   = 1'b0;
        abort = 1'b0;
        check("t6_rst_sum", 32'(sum), 0);
        check("t6_rst_valid", 32'(sum_valid), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_cnt", 32'(term_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            mac_out = 16'(i + 9);
            step();
            check("t6_idle_cnt", 32'(term_cnt), 0);
            check("t6_idle_busy", 32'(busy), 0);
        end
        in_valid = 1'b0;

        idle_cycles(3);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mac_dot_accum.md
MAC_DOT_ACCUM -- requirements
Module: mac_dot_accum

Interface
REQ-001 SHALL have parameter IN_W, default 16, the width of the MAC result word (out) consumed each cycle.
REQ-002 SHALL have parameter LEN_W, default 4, the width of the term-count field; the maximum term count is 2**LEN_W.
REQ-003 SHALL have parameter SUM_W, default IN_W+1+LEN_W (21), the accumulator width.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  begin a new dot-product; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of terms, latched on start; 0 means 2**LEN_W terms.
REQ-008 abort  input  1  synchronous cancel; returns to IDLE from any state.
REQ-009 in_valid  input  1  mac_out and mac_cout carry a valid term this cycle.
REQ-010 mac_out  input  IN_W  upstream MAC out word.
REQ-011 mac_cout  input  1  upstream MAC cout, the term MSB.
REQ-012 sum  output  SUM_W  accumulated result; valid only while sum_valid is high.
REQ-013 sum_valid  output  1  result available.
REQ-014 sum_ready  input  1  downstream accepts sum.
REQ-015 busy  output  1  high in ACCUM and DONE.
REQ-016 term_cnt  output  LEN_W+1  number of terms accepted in the current operation.

Function
REQ-017 SHALL implement states IDLE, ACCUM and DONE.
REQ-018 In IDLE with start=1, SHALL latch len, clear the accumulator and term_cnt to 0, and enter ACCUM on the next cycle.
REQ-019 In ACCUM, on each cycle with in_valid=1, SHALL add the zero-extended term {mac_cout, mac_out} (IN_W+1 bits) to the accumulator and increment term_cnt.
REQ-020 SHALL move to DONE in the cycle after the term that brings term_cnt equal to the latched length; sum_valid SHALL be high from that cycle.
REQ-021 In ACCUM with in_valid=0, SHALL hold all state.
REQ-022 In DONE, sum and sum_valid SHALL hold stable until sum_ready=1; the handshake completes on the edge where sum_valid=1 and sum_ready=1, and the next state is IDLE.
REQ-023 start SHALL be ignored outside IDLE, including in the DONE cycle that completes the handshake; a new operation needs start in IDLE.
REQ-024 in_valid SHALL be ignored in IDLE and DONE; no term is accumulated in those states.
REQ-025 abort SHALL take priority over start, in_valid and sum_ready: next state IDLE, sum_valid low, accumulator and term_cnt cleared.
REQ-026 The accumulator SHALL never overflow: the maximum is 2**LEN_W × (2**(IN_W+1) − 1), which is 0x1FFFF0 at the default parameters.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 The minimum operation latency SHALL be: start cycle, then len terms on consecutive cycles, then sum_valid on the next cycle.

Reset
REQ-029 While rst=1 at a clock edge, SHALL set state to IDLE, sum to 0, sum_valid to 0, term_cnt to 0, the latched length to 0 and busy to 0.
REQ-030 rst SHALL override every input, including abort, and SHALL discard any operation in progress.

Structure
REQ-031 The package mac_pkg SHALL hold the IN_W, LEN_W and SUM_W defaults and the state encoding (IDLE=0, ACCUM=1, DONE=2); the upstream MAC and its bench share it.
REQ-032 The block SHALL be a single module with one registered state machine and one registered accumulator datapath; no sub-module is needed.

Verification
REQ-033 The bench SHALL cover: start with len=5, then terms 150, 500, 1500, 20000, 65025 (products 15×10, 20×25, 50×30, 100×200, 255×255) on consecutive cycles -> sum=87175, sum_valid high the cycle after the 5th term, term_cnt=5.
REQ-034 The bench SHALL cover: len=0 with 16 terms of {cout=1, out=0xFFFF} -> sum=0x1FFFF0, with no overflow.
REQ-035 The bench SHALL cover: len=3, terms 10, 20, 30 with in_valid low for 2 cycles between terms -> sum=60, and the idle cycles add nothing.
REQ-036 The bench SHALL cover: in DONE, sum_ready held low for 4 cycles, then high -> sum stable throughout, IDLE the following cycle; a start in the handshake cycle is ignored (busy stays 0).
REQ-037 The bench SHALL cover: abort after 2 of 4 terms -> IDLE next cycle, sum_valid=0; a new start with len=1 and term 7 -> sum=7.
REQ-038 The bench SHALL cover: rst asserted mid-ACCUM -> all outputs 0 on the next edge; in_valid pulses while IDLE -> term_cnt stays 0.
